// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module  : uart_pkg
// Purpose : Shared UART constants and receive/transmit bit-FSM state encoding.
// Revision: 1.0 - initial release
// ============================================================================
package uart_pkg;

  localparam int c_CLKS_PER_BIT_DEFAULT    = 10417;
  localparam int c_BYTES_PER_FRAME_DEFAULT = 9216;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_rx_byte.sv
`default_nettype none
// ============================================================================
// Module  : uart_rx_byte
// Purpose : Input synchronizer and bit FSM; strobes valid/error at the stop
//           sample. Even parity compiled in with UART_RX_PARITY_EN.
// Revision: 1.0 - initial release
// ============================================================================
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = c_CLKS_PER_BIT_DEFAULT
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Rx,
  output logic [7:0] o_Byte,
  output logic       o_Valid,
  output logic       o_Error,
  output logic       o_Idle
);

  localparam int                 c_CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [c_CNT_W-1:0] c_HALF  = c_CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(CLKS_PER_BIT - 1);

  logic               r_Rx_Meta;
  logic               r_Rx_Sync;
  uart_state_t        r_State;
  uart_state_t        w_Next_State;
  logic [c_CNT_W-1:0] r_Count;
  logic [2:0]         r_Bit_Idx;
  logic [7:0]         r_Shift;
  logic               w_Cnt_Clr;
  logic               w_Shift_En;
  logic               w_Valid;
  logic               w_Error;
  logic               w_Par_Ok;
`ifdef UART_RX_PARITY_EN
  logic               r_Par_Err;
  logic               w_Par_En;
  assign w_Par_Ok = ~r_Par_Err;
`else
  assign w_Par_Ok = 1'b1;
`endif

  always_comb begin
    w_Next_State = r_State;
    w_Cnt_Clr    = 1'b0;
    w_Shift_En   = 1'b0;
    w_Valid      = 1'b0;
    w_Error      = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_Par_En     = 1'b0;
`endif
    case (r_State)
      IDLE: begin
        w_Cnt_Clr = 1'b1;
        if (!r_Rx_Sync) w_Next_State = START;
      end
      START: begin
        if (r_Count == c_HALF) begin
          w_Cnt_Clr    = 1'b1;
          w_Next_State = r_Rx_Sync ? IDLE : DATA;
        end
      end
      DATA: begin
        if (r_Count == c_LAST) begin
          w_Cnt_Clr  = 1'b1;
          w_Shift_En = 1'b1;
          if (r_Bit_Idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            w_Next_State = PARITY;
`else
            w_Next_State = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (r_Count == c_LAST) begin
          w_Cnt_Clr    = 1'b1;
          w_Par_En     = 1'b1;
          w_Next_State = STOP;
        end
      end
`endif
      STOP: begin
        if (r_Count == c_LAST) begin
          w_Cnt_Clr    = 1'b1;
          w_Next_State = IDLE;
          if (r_Rx_Sync && w_Par_Ok) w_Valid = 1'b1;
          else                       w_Error = 1'b1;
        end
      end
      default: w_Next_State = IDLE;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_Rx_Meta <= 1'b1;
      r_Rx_Sync <= 1'b1;
      r_State   <= IDLE;
      r_Count   <= '0;
      r_Bit_Idx <= '0;
      r_Shift   <= '0;
`ifdef UART_RX_PARITY_EN
      r_Par_Err <= 1'b0;
`endif
    end else begin
      r_Rx_Meta <= i_Rx;
      r_Rx_Sync <= r_Rx_Meta;
      r_State   <= w_Next_State;
      r_Count   <= w_Cnt_Clr ? '0 : r_Count + 1'b1;
      if (r_State == START) r_Bit_Idx <= '0;
      else if (w_Shift_En)  r_Bit_Idx <= r_Bit_Idx + 1'b1;
      // LSB arrives first, so shift in from the top
      if (w_Shift_En) r_Shift <= {r_Rx_Sync, r_Shift[7:1]};
`ifdef UART_RX_PARITY_EN
      if (r_State == START) r_Par_Err <= 1'b0;
      else if (w_Par_En)    r_Par_Err <= r_Rx_Sync ^ (^r_Shift);
`endif
    end
  end

  assign o_Byte  = r_Shift;
  assign o_Valid = w_Valid;
  assign o_Error = w_Error;
  assign o_Idle  = (r_State == IDLE);

endmodule
`default_nettype wire

// File: rtl/uart_frame_rx.sv
`default_nettype none
// ============================================================================
// Module  : uart_frame_rx
// Purpose : UART frame receiver writing good bytes to sequential RAM addresses,
//           with frame-done, idle-timeout abort and byte-error pulses.
//           Optional even parity: define UART_RX_PARITY_EN.
// Revision: 1.0 - initial release
// ============================================================================
module uart_frame_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT    = c_CLKS_PER_BIT_DEFAULT,
  parameter int BYTES_PER_FRAME = c_BYTES_PER_FRAME_DEFAULT,
  parameter int ADDR_W          = 14,
  parameter int TIMEOUT_BITS    = 64
) (
  input  logic              i_Clk,
  input  logic              i_Rst,
  input  logic              i_Rx,
  output logic [7:0]        o_RAM_Data,
  output logic [ADDR_W-1:0] o_Write_Adress,
  output logic              o_Enable_Write,
  output logic              o_Frame_Done,
  output logic              o_Frame_Abort,
  output logic              o_Byte_Error
);

  localparam int                  c_TIMEOUT_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int                  c_IDLE_W         = $clog2(c_TIMEOUT_CYCLES);
  localparam logic [c_IDLE_W-1:0] c_IDLE_LAST      = c_IDLE_W'(c_TIMEOUT_CYCLES - 1);
  localparam logic [ADDR_W-1:0]   c_LAST_ADDR      = ADDR_W'(BYTES_PER_FRAME - 1);

  logic [7:0]          w_Byte;
  logic                w_Valid;
  logic                w_Error;
  logic                w_Idle;
  logic [ADDR_W-1:0]   r_Byte_Count;
  logic [c_IDLE_W-1:0] r_Idle_Count;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx_byte (
    .i_Clk  (i_Clk),
    .i_Rst  (i_Rst),
    .i_Rx   (i_Rx),
    .o_Byte (w_Byte),
    .o_Valid(w_Valid),
    .o_Error(w_Error),
    .o_Idle (w_Idle)
  );

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      o_RAM_Data     <= '0;
      o_Write_Adress <= '0;
      o_Enable_Write <= 1'b0;
      o_Frame_Done   <= 1'b0;
      o_Frame_Abort  <= 1'b0;
      o_Byte_Error   <= 1'b0;
      r_Byte_Count   <= '0;
      r_Idle_Count   <= '0;
    end else begin
      o_Enable_Write <= w_Valid;
      o_Frame_Done   <= w_Valid && !w_Error && (r_Byte_Count == c_LAST_ADDR);
      o_Byte_Error   <= w_Error;
      o_Frame_Abort  <= 1'b0;
      if (w_Valid) begin
        o_RAM_Data     <= w_Byte;
        o_Write_Adress <= r_Byte_Count;
        r_Byte_Count   <= (r_Byte_Count == c_LAST_ADDR) ? '0 : r_Byte_Count + 1'b1;
      end
      // Valid only fires outside IDLE, so it never races the abort below
      if (w_Idle && (r_Byte_Count != '0)) begin
        if (r_Idle_Count == c_IDLE_LAST) begin
          o_Frame_Abort <= 1'b1;
          r_Byte_Count  <= '0;
          r_Idle_Count  <= '0;
        end else begin
          r_Idle_Count <= r_Idle_Count + 1'b1;
        end
      end else begin
        r_Idle_Count <= '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_frame_rx.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_frame_rx
// Purpose : Self-checking bench for uart_frame_rx (UART_RX_PARITY_EN optional).
// Revision: 1.0 - initial release
// ============================================================================
module tb_uart_frame_rx;

  localparam int CPB    = 16;
  localparam int BPF    = 4;
  localparam int ADDR_W = 14;
  localparam int TO_B   = 4;
  localparam int TO     = TO_B * CPB;
  localparam int H      = CPB / 2;
`ifdef UART_RX_PARITY_EN
  localparam int PBITS  = 1;
`else
  localparam int PBITS  = 0;
`endif

  logic              i_Clk = 1'b0;
  logic              i_Rst = 1'b1;
  logic              i_Rx  = 1'b1;
  logic [7:0]        o_RAM_Data;
  logic [ADDR_W-1:0] o_Write_Adress;
  logic              o_Enable_Write;
  logic              o_Frame_Done;
  logic              o_Frame_Abort;
  logic              o_Byte_Error;

  uart_frame_rx #(
    .CLKS_PER_BIT(CPB), .BYTES_PER_FRAME(BPF), .ADDR_W(ADDR_W), .TIMEOUT_BITS(TO_B)
  ) dut (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Rx(i_Rx),
    .o_RAM_Data(o_RAM_Data), .o_Write_Adress(o_Write_Adress),
    .o_Enable_Write(o_Enable_Write), .o_Frame_Done(o_Frame_Done),
    .o_Frame_Abort(o_Frame_Abort), .o_Byte_Error(o_Byte_Error)
  );

  always #5 i_Clk = ~i_Clk;

  int cyc = 0;
  always @(posedge i_Clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [7:0]        d;
    logic [ADDR_W-1:0] a;
    logic              done;
  } wr_t;

  // Expected events keyed by the cycle index in which the DUT output is high
  wr_t exp_wr[int];
  bit  exp_err[int];
  bit  exp_abort[int];
  int  m_cnt    = 0;
  int  abort_at = -1;
  bit  chk_en   = 1'b0;

  int n_checks = 0;
  int n_err    = 0;

  logic [7:0]        cap_d[$];
  logic [ADDR_W-1:0] cap_a[$];
  logic              cap_done[$];
  int                cap_cyc[$];
  int                n_abort_seen = 0;
  int                n_err_seen   = 0;
  int                first_c0     = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // A frame in progress times out TO cycles after the receiver goes idle,
  // unless a start bit pulls the FSM out of IDLE first.
  task automatic resolve_abort(input int c0);
    if (abort_at >= 0) begin
      if (abort_at <= c0 + 3) m_cnt = 0;
      else exp_abort.delete(abort_at);
      abort_at = -1;
    end
  endtask

  task automatic note_idle(input int s);
    if (m_cnt != 0) begin
      abort_at = s + TO;
      exp_abort[abort_at] = 1'b1;
    end
  endtask

  task automatic hold_bit(input logic v);
    i_Rx = v;
    repeat (CPB) @(posedge i_Clk);
    #1;
  endtask

  task automatic idle(input int n);
    i_Rx = 1'b1;
    repeat (n) @(posedge i_Clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop_v, input logic par_flip);
    int  c0, wc;
    wr_t w;
    c0 = cyc;
    resolve_abort(c0);
    wc = c0 + 3 + H + (9 + PBITS) * CPB;
    if (stop_v && (PBITS == 0 || !par_flip)) begin
      w.d = d; w.a = ADDR_W'(m_cnt); w.done = (m_cnt == BPF - 1);
      exp_wr[wc] = w;
      m_cnt = (m_cnt == BPF - 1) ? 0 : m_cnt + 1;
    end else begin
      exp_err[wc] = 1'b1;
    end
    note_idle(wc);
    hold_bit(1'b0);
    for (int i = 0; i < 8; i++) hold_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    hold_bit((^d) ^ par_flip);
`endif
    hold_bit(stop_v);
  endtask

  always @(negedge i_Clk) begin
    wr_t w;
    if (chk_en) begin
      if (exp_wr.exists(cyc)) begin
        w = exp_wr[cyc];
        chk("write_strobe", o_Enable_Write, 1);
        chk("write_data", o_RAM_Data, w.d);
        chk("write_addr", o_Write_Adress, w.a);
        chk("frame_done", o_Frame_Done, w.done);
      end else begin
        chk("write_strobe", o_Enable_Write, 0);
        chk("frame_done", o_Frame_Done, 0);
      end
      chk("byte_error", o_Byte_Error, exp_err.exists(cyc));
      chk("frame_abort", o_Frame_Abort, exp_abort.exists(cyc));
      if (o_Enable_Write === 1'b1) begin
        cap_d.push_back(o_RAM_Data);
        cap_a.push_back(o_Write_Adress);
        cap_done.push_back(o_Frame_Done);
        cap_cyc.push_back(cyc);
      end
      if (o_Frame_Abort === 1'b1) n_abort_seen++;
      if (o_Byte_Error === 1'b1) n_err_seen++;
    end
  end

  initial begin
    repeat (3) @(posedge i_Clk);
    #1;
    chk("rst_data", o_RAM_Data, 0);
    chk("rst_addr", o_Write_Adress, 0);
    chk("rst_we", o_Enable_Write, 0);
    chk("rst_pulses", {o_Frame_Done, o_Frame_Abort, o_Byte_Error}, 0);
    i_Rst  = 1'b0;
    chk_en = 1'b1;
    idle(4);

    // Full frame, then a fifth byte that wraps to address 0 and later times out
    first_c0 = cyc;
    send_byte(8'hA5, 1'b1, 1'b0);
    send_byte(8'h3C, 1'b1, 1'b0);
    send_byte(8'hFF, 1'b1, 1'b0);
    send_byte(8'h00, 1'b1, 1'b0);
    send_byte(8'h5A, 1'b1, 1'b0);
    idle(100);

    // Short low glitch on the line
    begin
      int c0;
      c0 = cyc;
      resolve_abort(c0);
      i_Rx = 1'b0;
      repeat (5) @(posedge i_Clk);
      #1;
      i_Rx = 1'b1;
      note_idle(c0 + 3 + H);
      idle(40);
    end

    // Bad stop bit, then two good bytes and a mid-frame timeout
    send_byte(8'h55, 1'b0, 1'b0);
    idle(2 * CPB);
    send_byte(8'h11, 1'b1, 1'b0);
    send_byte(8'h22, 1'b1, 1'b0);
    idle(100);

    // Reset during bit 4 of a byte while a frame is partially stored
    send_byte(8'h33, 1'b1, 1'b0);
    send_byte(8'h44, 1'b1, 1'b0);
    begin
      logic [7:0] d;
      d = 8'hF0;
      resolve_abort(cyc);
      hold_bit(1'b0);
      for (int i = 0; i < 4; i++) hold_bit(d[i]);
      i_Rx = d[4];
      repeat (5) @(posedge i_Clk);
      #1;
      i_Rst = 1'b1;
      @(posedge i_Clk);
      #1;
      i_Rst = 1'b0;
      m_cnt = 0;
      chk("midrst_data", o_RAM_Data, 0);
      chk("midrst_addr", o_Write_Adress, 0);
      chk("midrst_we", o_Enable_Write, 0);
      idle(10 * CPB);
    end
    send_byte(8'h81, 1'b1, 1'b0);
    idle(100);

`ifdef UART_RX_PARITY_EN
    send_byte(8'h07, 1'b1, 1'b0);
    send_byte(8'h07, 1'b1, 1'b1);
    idle(100);
`endif

    // Hand-computed pins on the observed write sequence
    chk("n_writes", cap_d.size(), 10 + PBITS);
    if (cap_d.size() >= 10) begin
      chk("lat_first", cap_cyc[0] - first_c0, 2 + 8 + 144 + 1 + 16 * PBITS);
      chk("pin_d0", cap_d[0], 8'hA5);
      chk("pin_a1", cap_a[1], 1);
      chk("pin_d2", cap_d[2], 8'hFF);
      chk("pin_done3", {cap_done[3], cap_a[3], cap_d[3]}, {1'b1, 14'd3, 8'h00});
      chk("pin_wrap4", {cap_done[4], cap_a[4], cap_d[4]}, {1'b0, 14'd0, 8'h5A});
      chk("pin_after_err", {cap_a[5], cap_d[5]}, {14'd0, 8'h11});
      chk("pin_after_abort", {cap_a[7], cap_d[7]}, {14'd0, 8'h33});
      chk("pin_after_rst", {cap_a[9], cap_d[9]}, {14'd0, 8'h81});
    end
    chk("n_aborts", n_abort_seen, 3 + PBITS);
    chk("n_byte_errors", n_err_seen, 1 + PBITS);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire
